// File: rtl/pwm_meas_pkg.sv
// Shared definitions for the PWM duty meter: capture states, synchroniser depth
// and default widths.
package pwm_meas_pkg;

    localparam int unsigned SYNC_DEPTH  = 2;
    localparam int unsigned CNT_W_DEF   = 24;
    localparam int unsigned DUTY_W_DEF  = 8;
    localparam int unsigned TIMEOUT_DEF = 5_000_000;

    typedef enum logic [1:0] {
        CAP_ARM,
        CAP_HIGH,
        CAP_LOW
    } cap_state_t;

endpackage

// File: rtl/pwm_duty_div.sv
// Serial restoring divider: quotient = floor((h << DUTY_W) / p), one bit per cycle.
// Requires h < p, so the quotient always fits DUTY_W bits.
module pwm_duty_div #(
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  h,
    input  logic [CNT_W-1:0]  p,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] quotient
);

    localparam int unsigned STEP_W = $clog2(DUTY_W + 1);

    logic [CNT_W:0]    rem;
    logic [CNT_W:0]    den;
    logic [CNT_W:0]    rem_sh;
    logic [CNT_W:0]    diff;
    logic              ge;
    logic [DUTY_W-1:0] q;
    logic [DUTY_W-1:0] q_nx;
    logic [STEP_W-1:0] steps;

    // rem < den always holds, so shifting left never loses a set MSB.
    always_comb begin
        rem_sh = rem << 1;
        diff   = rem_sh - den;
        ge     = (rem_sh >= den);
        q_nx   = (q << 1) | DUTY_W'(ge);
    end

    assign done     = busy && (steps == STEP_W'(1));
    assign quotient = q_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem   <= '0;
            den   <= '0;
            q     <= '0;
            steps <= '0;
            busy  <= 1'b0;
        end else if (!busy) begin
            if (start) begin
                rem   <= {1'b0, h};
                den   <= {1'b0, p};
                q     <= '0;
                steps <= STEP_W'(DUTY_W);
                busy  <= 1'b1;
            end
        end else begin
            rem   <= ge ? diff : rem_sh;
            q     <= q_nx;
            steps <= steps - STEP_W'(1);
            if (steps == STEP_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time, period and duty of an asynchronous PWM input and flags a
// line that has stopped toggling.
module pwm_duty_meter
    import pwm_meas_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned DUTY_W  = DUTY_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  high_cnt,
    output logic [CNT_W-1:0]  period_cnt,
    output logic [DUTY_W-1:0] duty,
    output logic              meas_valid,
    output logic              stuck,
    output logic              stuck_level,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] AGE_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] AGE_MAX  = CNT_W'(TIMEOUT);

    logic [SYNC_DEPTH-1:0] sync;
    logic                  pwm_s;
    logic                  pwm_d;
    logic                  rise;
    logic                  fall;
    logic                  any_edge;

    logic [CNT_W-1:0]      pcnt;
    logic [CNT_W-1:0]      hcnt;
    logic [CNT_W-1:0]      edge_age;
    logic [CNT_W-1:0]      h_lat;
    logic [CNT_W-1:0]      p_lat;

    cap_state_t            state;
    cap_state_t            state_nx;
    logic                  timeout_hit;
    logic                  div_start;
    logic                  set_overrun;
    logic                  clr_stuck;

    logic                  div_busy;
    logic                  div_done;
    logic [DUTY_W-1:0]     div_q;

    assign pwm_s    = sync[SYNC_DEPTH-1];
    assign rise     = pwm_s & ~pwm_d;
    assign fall     = ~pwm_s & pwm_d;
    assign any_edge = rise | fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= '0;
            pwm_d    <= 1'b0;
            pcnt     <= '0;
            hcnt     <= '0;
            edge_age <= '0;
        end else begin
            sync  <= {sync[SYNC_DEPTH-2:0], pwm_in};
            pwm_d <= pwm_s;

            if (rise) begin
                pcnt <= CNT_W'(1);
            end else if (pcnt != '1) begin
                pcnt <= pcnt + CNT_W'(1);
            end

            if (rise) begin
                hcnt <= CNT_W'(1);
            end else if (pwm_s && hcnt != '1) begin
                hcnt <= hcnt + CNT_W'(1);
            end

            if (any_edge) begin
                edge_age <= '0;
            end else if (edge_age != AGE_MAX) begin
                edge_age <= edge_age + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CAP_ARM;
        end else begin
            state <= state_nx;
        end
    end

    // Timeout fires once: edge_age saturates past TIMEOUT-1 until the next edge.
    always_comb begin
        state_nx    = state;
        div_start   = 1'b0;
        set_overrun = 1'b0;
        clr_stuck   = 1'b0;
        timeout_hit = !any_edge && (edge_age == AGE_LAST);

        if (timeout_hit) begin
            state_nx = CAP_ARM;
        end else begin
            unique case (state)
                CAP_ARM: begin
                    if (rise) begin
                        state_nx  = CAP_HIGH;
                        clr_stuck = 1'b1;
                    end
                end
                CAP_HIGH: begin
                    if (fall) begin
                        state_nx = CAP_LOW;
                    end
                end
                CAP_LOW: begin
                    if (rise) begin
                        state_nx = CAP_HIGH;
                        if (div_busy) begin
                            set_overrun = 1'b1;
                        end else begin
                            div_start = 1'b1;
                        end
                    end
                end
                default: state_nx = CAP_ARM;
            endcase
        end
    end

    pwm_duty_div #(
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .h        (hcnt),
        .p        (pcnt),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            h_lat       <= '0;
            p_lat       <= '0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            duty        <= '0;
            meas_valid  <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;

            if (div_start) begin
                h_lat <= hcnt;
                p_lat <= pcnt;
            end

            if (set_overrun) begin
                overrun <= 1'b1;
            end

            if (clr_stuck) begin
                stuck <= 1'b0;
            end

            if (timeout_hit) begin
                stuck       <= 1'b1;
                stuck_level <= pwm_s;
                high_cnt    <= '0;
                period_cnt  <= '0;
                duty        <= {DUTY_W{pwm_s}};
                meas_valid  <= 1'b1;
            end else if (div_done) begin
                high_cnt   <= h_lat;
                period_cnt <= p_lat;
                duty       <= div_q;
                meas_valid <= 1'b1;
            end
        end
    end

endmodule
